icache_dm: RTL and testbench

- Direct-mapped instruction cache between the 256x16 instruction RAM and the processor fetch path (PC/IR).
- Serves PC addresses with single-cycle hits.
- Fills from instruction RAM on a miss and raises i_odv when the fetch word is valid.
- Write-through path lets the program loader write instruction RAM while keeping cached lines coherent.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_tag_array.sv | 48 ++++
 rtl/icache_dm.sv | 194 +++++++++++++++++++
 tb/tb_icache_dm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

   localparam int D_W_DEF     = 16;
   localparam int A_W_DEF     = 8;
   localparam int LINES_DEF   = 4;
   localparam int MEM_LAT_DEF = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RESP = 2'd2
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int bits_for(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W_DEF = bits_for(LINES_DEF);
   localparam int TAG_W_DEF = A_W_DEF - IDX_W_DEF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag/data storage for the cache lines: combinational lookup,
// one synchronous write port, valid bits cleared asynchronously.
module icache_tag_array
   import icache_pkg::*;
#(
   parameter int D_WIDTH = D_W_DEF,
   parameter int LINES   = LINES_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [IDX_W-1:0]   i_rd_idx,
   input  logic [TAG_W-1:0]   i_rd_tag,
   output logic               o_hit,
   output logic [D_WIDTH-1:0] o_rdata,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [D_WIDTH-1:0] i_wr_data
);

   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [D_WIDTH-1:0] r_data [LINES];

   // Lookup of the line selected by the fetch address.
   always_comb begin
      o_hit   = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
      o_rdata = r_data[i_rd_idx];
   end

   // Line storage; any write leaves the line valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < LINES; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_tag[i_wr_idx]   <= i_wr_tag;
         r_data[i_wr_idx]  <= i_wr_data;
      end
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with write-through program loading.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module icache_dm
   import icache_pkg::*;
#(
   parameter int D_WIDTH = D_W_DEF,
   parameter int A_WIDTH = A_W_DEF,
   parameter int LINES   = LINES_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic               g_clk,
   input  logic               g_clr,
   input  logic [A_WIDTH-1:0] cpu_addr,
   input  logic               cpu_rd,
   input  logic               cpu_wr,
   input  logic [D_WIDTH-1:0] cpu_wdata,
   output logic [D_WIDTH-1:0] cpu_rdata,
   output logic               i_odv,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic [D_WIDTH-1:0] mem_wdata,
   input  logic [D_WIDTH-1:0] mem_rdata,
   output logic [7:0]         hit_cnt,
   output logic [7:0]         miss_cnt
);

   localparam int IW = bits_for(LINES);
   localparam int TW = A_WIDTH - IW;
   localparam int CW = bits_for(MEM_LAT);

   state_t             r_state;
   state_t             w_next;
   logic [A_WIDTH-1:0] r_addr;
   logic [CW-1:0]      r_cnt;
   logic [D_WIDTH-1:0] r_fill;
   logic [D_WIDTH-1:0] r_last;

   logic               w_req_rd;
   logic               w_req_wr;
   logic               w_hit;
   logic [D_WIDTH-1:0] w_line;
   logic               w_miss;
   logic               w_fill_done;
   logic               w_wr_en;
   logic [IW-1:0]      w_wr_idx;
   logic [TW-1:0]      w_wr_tag;
   logic [D_WIDTH-1:0] w_wr_data;

   // Requests are masked while reset is held so the outputs read zero at once.
   assign w_req_rd = cpu_rd & g_clr;
   assign w_req_wr = cpu_wr & g_clr;

   icache_tag_array #(
      .D_WIDTH (D_WIDTH),
      .LINES   (LINES),
      .IDX_W   (IW),
      .TAG_W   (TW)
   ) u_tags (
      .i_clk     (g_clk),
      .i_rst_n   (g_clr),
      .i_rd_idx  (cpu_addr[IW-1:0]),
      .i_rd_tag  (cpu_addr[A_WIDTH-1:IW]),
      .o_hit     (w_hit),
      .o_rdata   (w_line),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_tag  (w_wr_tag),
      .i_wr_data (w_wr_data)
   );

   // Next state, memory strobes, response mux and line-write control.
   always_comb begin
      w_next      = r_state;
      mem_addr    = cpu_addr;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_wdata   = cpu_wdata;
      i_odv       = 1'b0;
      cpu_rdata   = r_last;
      w_miss      = 1'b0;
      w_fill_done = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_idx    = cpu_addr[IW-1:0];
      w_wr_tag    = cpu_addr[A_WIDTH-1:IW];
      w_wr_data   = cpu_wdata;
      case (r_state)
         IDLE: begin
            if (w_req_wr) begin
               mem_wr  = 1'b1;
               i_odv   = 1'b1;
               w_wr_en = w_hit;
            end else if (w_req_rd && w_hit) begin
               cpu_rdata = w_line;
               i_odv     = 1'b1;
            end else if (w_req_rd) begin
               mem_rd = 1'b1;
               w_miss = 1'b1;
               w_next = FILL;
            end else begin
               w_next = IDLE;
            end
         end
         FILL: begin
            mem_addr  = r_addr;
            w_wr_idx  = r_addr[IW-1:0];
            w_wr_tag  = r_addr[A_WIDTH-1:IW];
            w_wr_data = mem_rdata;
            if (r_cnt == '0) begin
               w_fill_done = 1'b1;
               w_wr_en     = 1'b1;
               w_next      = RESP;
            end else begin
               w_next = FILL;
            end
         end
         RESP: begin
            mem_addr = r_addr;
            w_next   = IDLE;
            if (w_req_rd && (cpu_addr == r_addr)) begin
               cpu_rdata = r_fill;
               i_odv     = 1'b1;
            end else begin
               i_odv = 1'b0;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Miss address latch, RAM wait counter, fill word and last delivered word.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_fill <= '0;
         r_last <= '0;
      end else begin
         if (w_miss) begin
            r_addr <= cpu_addr;
            r_cnt  <= CW'(MEM_LAT - 1);
         end else if ((r_state == FILL) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_fill_done) begin
            r_fill <= mem_rdata;
         end
         if (i_odv) begin
            r_last <= cpu_rdata;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   logic       w_rd_hit;
   logic [7:0] r_hit_cnt;
   logic [7:0] r_miss_cnt;

   assign w_rd_hit = (r_state == IDLE) && w_req_rd && !w_req_wr && w_hit;

   // Saturating hit/miss statistics.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_hit_cnt  <= 8'h00;
         r_miss_cnt <= 8'h00;
      end else begin
         if (w_rd_hit) begin
            r_hit_cnt <= sat_inc8(r_hit_cnt);
         end
         if (w_miss) begin
            r_miss_cnt <= sat_inc8(r_miss_cnt);
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = 8'h00;
   assign miss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against a line-occupancy model.
module tb_icache_dm;

   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int NL  = 4;
   localparam int LAT = 1;

   logic          g_clk = 1'b0;
   logic          g_clr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_rd = 1'b0;
   logic          cpu_wr = 1'b0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          i_odv;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [7:0]    hit_cnt;
   logic [7:0]    miss_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   icache_dm #(.D_WIDTH(DW), .A_WIDTH(AW), .LINES(NL), .MEM_LAT(LAT)) dut (
      .g_clk(g_clk), .g_clr(g_clr), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
      .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .i_odv(i_odv),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 g_clk = ~g_clk;

   // Instruction RAM seen by the DUT, plus the bench's own view of its contents.
   logic [DW-1:0] ram     [256];
   logic [DW-1:0] ref_ram [256];
   logic [DW-1:0] rd_pipe [LAT];
   logic          load_ram = 1'b0;

   always @(posedge g_clk) begin
      if (load_ram) begin
         for (int i = 0; i < 256; i++) ram[i] <= ref_ram[i];
      end else if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
      end
      rd_pipe[0] <= mem_rd ? ram[mem_addr] : 16'hDEAD;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // Model: which full address each line currently holds.
   bit            m_valid [NL];
   logic [AW-1:0] m_addr  [NL];
   int            m_hits = 0;
   int            m_misses = 0;

   function automatic bit m_lookup(input logic [AW-1:0] a);
      return m_valid[a % NL] && (m_addr[a % NL] == a);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input string tag);
      bit            exp_hit = m_lookup(a);
      int            cyc = 0;
      int            nrd = 0;
      bit            seen = 1'b0;
      logic [DW-1:0] got = '0;
      logic [AW-1:0] rd_addr = '0;
      cpu_addr = a;
      cpu_wr   = 1'b0;
      cpu_rd   = 1'b1;
      while (!seen && cyc < 20) begin
         cyc++;
         @(negedge g_clk);
         if (mem_rd) begin
            nrd++;
            rd_addr = mem_addr;
         end
         if (i_odv) begin
            seen = 1'b1;
            got  = cpu_rdata;
         end
         @(posedge g_clk); #1;
      end
      cpu_rd = 1'b0;
      check_eq({tag, " odv"}, 32'(seen), 32'd1);
      check_eq({tag, " latency"}, cyc, exp_hit ? 32'd1 : 32'(LAT + 2));
      check_eq({tag, " mem_rd count"}, nrd, exp_hit ? 32'd0 : 32'd1);
      if (!exp_hit) check_eq({tag, " mem_addr"}, 32'(rd_addr), 32'(a));
      check_eq({tag, " data"}, 32'(got), 32'(ref_ram[a]));
      if (exp_hit) begin
         m_hits++;
      end else begin
         m_misses++;
         m_valid[a % NL] = 1'b1;
         m_addr[a % NL]  = a;
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input string tag, input bit also_rd);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wr    = 1'b1;
      cpu_rd    = also_rd;
      @(negedge g_clk);
      check_eq({tag, " mem_wr"}, 32'(mem_wr), 32'd1);
      check_eq({tag, " odv"}, 32'(i_odv), 32'd1);
      check_eq({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
      check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
      check_eq({tag, " mem_wdata"}, 32'(mem_wdata), 32'(d));
      @(posedge g_clk); #1;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      ref_ram[a] = d;
   endtask

   task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
      check_eq({tag, " hit_cnt"}, 32'(hit_cnt), (m_hits > 255) ? 32'd255 : 32'(m_hits));
      check_eq({tag, " miss_cnt"}, 32'(miss_cnt), (m_misses > 255) ? 32'd255 : 32'(m_misses));
`else
      check_eq({tag, " hit_cnt"}, 32'(hit_cnt), 32'd0);
      check_eq({tag, " miss_cnt"}, 32'(miss_cnt), 32'd0);
`endif
   endtask

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   logic [AW-1:0] pool [8] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'hFF, 8'hFB, 8'h33, 8'h37};
   logic [AW-1:0] ra;
   int            rsel;

   initial begin
      for (int i = 0; i < 256; i++) ref_ram[i] = 16'($urandom);
      ref_ram[8'h10] = 16'hABCD;
      for (int i = 0; i < NL; i++) m_addr[i] = '0;
      model_reset();
      load_ram = 1'b1;
      @(posedge g_clk); #1;
      load_ram = 1'b0;

      // Reset state
      check_eq("rst odv", 32'(i_odv), 32'd0);
      check_eq("rst mem_rd", 32'(mem_rd), 32'd0);
      check_eq("rst mem_wr", 32'(mem_wr), 32'd0);
      check_eq("rst rdata", 32'(cpu_rdata), 32'd0);
      check_stats("rst");
      @(negedge g_clk);
      g_clr = 1'b1;
      @(posedge g_clk); #1;

      // Directed cases
      do_read(8'h10, "cold 0x10");
      do_read(8'h10, "reread 0x10");
      do_read(8'h14, "conflict 0x14");
      do_read(8'h10, "conflict 0x10");
      do_read(8'h14, "cache 0x14");
      do_write(8'h14, 16'h1234, "write 0x14", 1'b0);
      do_read(8'h14, "hit after write");
      do_write(8'h20, 16'h5A5A, "write uncached", 1'b0);
      do_read(8'h20, "read after no-allocate");
      check_stats("directed");

      // Reset during a fill
      cpu_addr = 8'h33;
      cpu_rd   = 1'b1;
      @(negedge g_clk);
      check_eq("midfill mem_rd", 32'(mem_rd), 32'd1);
      @(posedge g_clk); #1;
      g_clr = 1'b0;
      #1;
      check_eq("midfill rst mem_rd", 32'(mem_rd), 32'd0);
      check_eq("midfill rst mem_wr", 32'(mem_wr), 32'd0);
      check_eq("midfill rst odv", 32'(i_odv), 32'd0);
      check_eq("midfill rst rdata", 32'(cpu_rdata), 32'd0);
      model_reset();
      check_stats("midfill rst");
      @(posedge g_clk); #1;
      cpu_rd = 1'b0;
      @(negedge g_clk);
      g_clr = 1'b1;
      @(posedge g_clk); #1;
      do_read(8'h33, "after reset 0x33");
      do_read(8'h10, "after reset 0x10");

      // Address wrap
      do_read(8'hFF, "wrap 0xFF");
      do_read(8'h00, "wrap 0x00");
      do_read(8'hFF, "wrap 0xFF hit");

      // Hit counter saturation
      for (int i = 0; i < 300; i++) do_read(8'h00, "hit loop");
      check_stats("saturate");

      // Random mix of reads and write-through loads
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) ra = 8'($urandom_range(0, 255));
         else ra = pool[$urandom_range(0, 7)];
         rsel = $urandom_range(0, 99);
         if (rsel < 30) do_write(ra, 16'($urandom), "rnd write", rsel < 10);
         else do_read(ra, "rnd read");
      end
      check_stats("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
